// File: rtl/mod_arith_pkg.sv
// Shared widths and the modular-arithmetic FSM encoding, reused by the Montgomery stage.
package mod_arith_pkg;

    localparam int OP_W  = 1027;
    localparam int RES_W = OP_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_GO   = 3'd1,
        P1_WAIT = 3'd2,
        P2_GO   = 3'd3,
        P2_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

endpackage

// File: rtl/mpadder.sv
// Two-cycle multi-precision add/subtract: low half on the start edge, high half plus carry
// on the next edge. result is RES_W bits of two's complement over zero-extended operands.
module mpadder
    import mod_arith_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic [RES_W-1:0] result,
    output logic             done
);
    localparam int LO_W = RES_W / 2;
    localparam int HI_W = RES_W - LO_W;

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [LO_W:0]    lo_sum;

    logic             s1_valid;
    logic [LO_W-1:0]  lo_q;
    logic             c_q;
    logic [HI_W-1:0]  a_hi_q;
    logic [HI_W-1:0]  b_hi_q;

    // Subtraction is a + ~b + 1 over the full RES_W width, so the carry-in is the op bit.
    always_comb begin
        a_ext  = {1'b0, in_a};
        b_ext  = subtract ? ~{1'b0, in_b} : {1'b0, in_b};
        lo_sum = {1'b0, a_ext[LO_W-1:0]} + {1'b0, b_ext[LO_W-1:0]}
               + {{LO_W{1'b0}}, subtract};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            lo_q     <= '0;
            c_q      <= 1'b0;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            s1_valid <= start;
            done     <= s1_valid;
            if (start) begin
                lo_q   <= lo_sum[LO_W-1:0];
                c_q    <= lo_sum[LO_W];
                a_hi_q <= a_ext[RES_W-1:LO_W];
                b_hi_q <= b_ext[RES_W-1:LO_W];
            end
            if (s1_valid) begin
                result <= {a_hi_q + b_hi_q + {{(HI_W-1){1'b0}}, c_q}, lo_q};
            end
        end
    end

endmodule

// File: rtl/mod_adder.sv
// Modular add/subtract: raw pass then a correction pass against M on one shared mpadder.
module mod_adder
    import mod_arith_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            subtract,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    input  logic [OP_W-1:0] in_m,
    output logic [OP_W-1:0] result,
    output logic            done,
    output logic            busy
);
    // Handshake: start is a one-cycle request honoured only in IDLE; done is a one-cycle
    // pulse with result valid in that cycle; busy covers accept+1 through the done cycle.
    state_t           state;
    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  b_q;
    logic [OP_W-1:0]  m_q;
    logic             op_q;
    logic [RES_W-1:0] r1_q;
    logic [RES_W-1:0] r2_q;

    logic             add_start;
    logic             add_sub;
    logic             add_done;
    logic [OP_W-1:0]  add_a;
    logic [OP_W-1:0]  add_b;
    logic [RES_W-1:0] add_res;
    logic             pass2;
    logic [OP_W-1:0]  final_val;

    // Bit RES_W-1 of a raw result flags a negative value.
    always_comb begin
        pass2   = (state == P2_GO);
        add_a   = pass2 ? r1_q[OP_W-1:0] : a_q;
        add_b   = pass2 ? m_q : b_q;
        add_sub = pass2 ? ~op_q : op_q;
        if (op_q) begin
            final_val = r1_q[RES_W-1] ? r2_q[OP_W-1:0] : r1_q[OP_W-1:0];
        end else begin
            final_val = r2_q[RES_W-1] ? r1_q[OP_W-1:0] : r2_q[OP_W-1:0];
        end
    end

    mpadder u_mpadder (
        .clk      (clk),
        .resetn   (resetn),
        .start    (add_start),
        .subtract (add_sub),
        .in_a     (add_a),
        .in_b     (add_b),
        .result   (add_res),
        .done     (add_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            op_q      <= 1'b0;
            r1_q      <= '0;
            r2_q      <= '0;
            add_start <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        a_q       <= in_a;
                        b_q       <= in_b;
                        m_q       <= in_m;
                        op_q      <= subtract;
                        add_start <= 1'b1;
                        state     <= P1_GO;
                    end
                end
                P1_GO: begin
                    add_start <= 1'b0;
                    state     <= P1_WAIT;
                end
                P1_WAIT: begin
                    if (add_done) begin
                        r1_q      <= add_res;
                        add_start <= 1'b1;
                        state     <= P2_GO;
                    end
                end
                P2_GO: begin
                    add_start <= 1'b0;
                    state     <= P2_WAIT;
                end
                P2_WAIT: begin
                    if (add_done) begin
                        r2_q  <= add_res;
                        state <= FIN;
                    end
                end
                FIN: begin
                    result <= final_val;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    add_start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mod_adder.md
Name: mod_adder

Overview:
Modular add/subtract stage that sits directly downstream of mpadder and drives it. It computes (a + b) mod M or (a - b) mod M for 1027-bit operands. It sequences two mpadder passes: the raw add/sub, then a correction pass against M. It feeds the Montgomery and exponentiation datapaths, which need fully reduced results.

Parameters:
OP_W, 1027, operand width; must match the mpadder in_a/in_b width.
RES_W, 1028, raw mpadder result width (OP_W+1); internal use only.

Ports:
clk  in  1  system clock, rising-edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  single-cycle request; sampled only in IDLE.
subtract  in  1  0: (a+b) mod M; 1: (a-b) mod M. Captured with start.
in_a  in  OP_W  operand a; caller guarantees a < M.
in_b  in  OP_W  operand b; caller guarantees b < M.
in_m  in  OP_W  modulus M; caller guarantees M[OP_W-1]==0 (M < 2^1026) and M > 0.
result  out  OP_W  reduced result, in range 0 to M-1. Registered.
done  out  1  one-cycle pulse when result becomes valid.
busy  out  1  high from the cycle after start is accepted until the cycle done pulses (inclusive).

Behaviour:
- Reset (asynchronous, resetn=0): FSM goes to IDLE; result=0; done=0; busy=0; all operand and intermediate registers cleared. The instantiated mpadder shares clk/resetn.
- Reset mid-operation: aborts immediately; no done pulse follows. The next start after release behaves as a fresh request.
- On an accepted start: in_a, in_b, in_m and subtract are captured into registers. Inputs may change afterwards.
- A start seen outside IDLE is ignored: no queuing and no effect on the current operation.
- FSM states: IDLE -> P1_GO -> P1_WAIT -> P2_GO -> P2_WAIT -> FIN -> IDLE.
  - P1_GO: one cycle. Assert adder start with in_a=a, in_b=b, subtract=op.
  - P1_WAIT: take the first cycle with adder done=1. Latch raw r1 (RES_W bits).
  - P2_GO: one cycle. Assert adder start with pass-2 operands (below).
  - P2_WAIT: take the first cycle with adder done=1. Latch raw r2.
  - FIN: register the final result and pulse done.
- Adder contract: the adder's done must be low in the cycle after its start. Adder done is ignored in every state except P1_WAIT and P2_WAIT.
- Add (op=0):
  - r1 = a+b, which is below 2^1027, so r1[1027]=0.
  - Pass 2: in_a=r1[1026:0], in_b=M, subtract=1.
  - Result = r2[1027] ? r1[1026:0] : r2[1026:0]. Bit 1027 set means the value is negative.
- Sub (op=1):
  - r1 = a-b in two's complement over RES_W bits.
  - Pass 2: in_a=r1[1026:0], in_b=M, subtract=0.
  - Result = r1[1027] ? r2[1026:0] : r1[1026:0]. The mod-2^1027 wrap of r2 yields a-b+M.
- Both passes always execute, so latency is constant for a given adder: 2*L_add + 4 cycles from the start edge to done, where L_add is the adder's start-to-done latency.
- Boundary cases:
  - a+b==M gives 0.
  - a==b on subtract gives 0.
  - a=b=0 gives 0.
  - a+b==M-1 takes the no-correction branch.
- Result holds its value from the done pulse until the next FIN; it is never cleared by start.

Decomposition:
- Shared package/header mod_arith_pkg: OP_W and RES_W localparams, plus the FSM state encoding (IDLE=0, P1_GO, P1_WAIT, P2_GO, P2_WAIT, FIN; 3 bits). The Montgomery stage reuses these widths.
- Exactly one sub-module: the existing mpadder, instantiated once and time-shared across both passes.
- All operand muxing and final selection live in mod_adder. No second adder.

Test Plan:
- M=13, add 7+9 -> result=3, done pulses once, busy high throughout. 5+3 -> result=8 (no correction).
- M=13, sub 3-9 -> result=7. Sub 9-3 -> result=6. Sub 4-4 -> result=0.
- M=13, add 6+7 -> result=0 (exact-M boundary). Add 0+0 -> 0. Add 12+12 -> 11.
- Large vector: M=2^1025+0x1F, a=b=M-1, add -> result=M-2. Sub a=0, b=M-1 -> result=1. Latency equals 2*L_add+4 in both cases.
- Assert start again while busy with different operands -> ignored; the first operation's result and a single done pulse are unchanged.
- Drive resetn low during P1_WAIT -> result=0, busy=0, no done pulse. After release, add 2+3 (M=13) -> 5.
